// File: rtl/mult_acc_stage_if.sv
// Handshake bundle between the 2x2 multiplier stage, the accumulator and the
// downstream consumer. The master drives start/products/result-ready; the
// slave (the accumulator) drives readiness, the result and status.
interface mult_acc_stage_if #(
    parameter int DATA_WIDTH  = 4,
    parameter int ACC_WIDTH   = 8,
    parameter int COUNT_WIDTH = 5
);
    logic                   start_i;
    logic [COUNT_WIDTH-1:0] len_i;
    logic [DATA_WIDTH-1:0]  prod_i;
    logic                   prod_valid_i;
    logic                   prod_ready_o;
    logic [ACC_WIDTH-1:0]   sum_o;
    logic                   sum_valid_o;
    logic                   sum_ready_i;
    logic                   ovf_o;
    logic                   busy_o;

    modport master (
        output start_i, len_i, prod_i, prod_valid_i, sum_ready_i,
        input  prod_ready_o, sum_o, sum_valid_o, ovf_o, busy_o
    );

    modport slave (
        input  start_i, len_i, prod_i, prod_valid_i, sum_ready_i,
        output prod_ready_o, sum_o, sum_valid_o, ovf_o, busy_o
    );
endinterface

// File: rtl/mult_acc_stage.sv
// Burst accumulator behind the multiplier stage: sums len_i unsigned products
// with saturation and hands the result downstream over a valid/ready handshake.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for a start with a non-zero length; result retained
// ACC   | accepting products, remaining count decrements per transfer
// DONE  | result valid, held stable until the consumer takes it
module mult_acc_stage #(
    parameter int DATA_WIDTH  = 4,
    parameter int ACC_WIDTH   = 8,
    parameter int COUNT_WIDTH = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    mult_acc_stage_if.slave   bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [COUNT_WIDTH-1:0] cnt_q, cnt_d;
    logic [ACC_WIDTH-1:0]   acc_q, acc_d;
    logic                   ovf_q, ovf_d;
    logic [ACC_WIDTH:0]     sum_ext;

    // One extra bit catches the carry out; zero-extend the product.
    assign sum_ext = {1'b0, acc_q} + (ACC_WIDTH+1)'(bus.prod_i);

    // State register, remaining count, accumulator and overflow flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            acc_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            ovf_q   <= ovf_d;
        end
    end

    // Next-state logic; start is only looked at in IDLE, so a start coinciding
    // with the DONE handshake is dropped and must be presented again.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        ovf_d   = ovf_q;
        case (state_q)
            IDLE: begin
                if (bus.start_i && (bus.len_i != '0)) begin
                    state_d = ACC;
                    cnt_d   = bus.len_i;
                    acc_d   = '0;
                    ovf_d   = 1'b0;
                end
            end
            ACC: begin
                if (bus.prod_valid_i) begin
                    // Once saturated at all-ones, any further add carries out
                    // or adds zero, so the value sticks for the rest of the burst.
                    if (sum_ext[ACC_WIDTH]) begin
                        acc_d = '1;
                        ovf_d = 1'b1;
                    end else begin
                        acc_d = sum_ext[ACC_WIDTH-1:0];
                    end
                    cnt_d = cnt_q - COUNT_WIDTH'(1);
                    if (cnt_q == COUNT_WIDTH'(1)) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                if (bus.sum_ready_i) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Outputs decode registered state only; nothing combinational from inputs.
    always_comb begin
        bus.prod_ready_o = (state_q == ACC);
        bus.sum_valid_o  = (state_q == DONE);
        bus.busy_o       = (state_q != IDLE);
        bus.sum_o        = acc_q;
        bus.ovf_o        = ovf_q;
    end

endmodule

// File: tb/tb_mult_acc_stage.sv
// Directed and randomized bursts checked against a plain-arithmetic model:
// expected result = min(sum of products, 2^ACC_WIDTH-1), overflow = sum too big.
module tb_mult_acc_stage;
    localparam int DW = 4;
    localparam int AW = 8;
    localparam int CW = 5;
    localparam int MAXV = (1 << AW) - 1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    mult_acc_stage_if #(.DATA_WIDTH(DW), .ACC_WIDTH(AW), .COUNT_WIDTH(CW)) bus ();

    mult_acc_stage #(.DATA_WIDTH(DW), .ACC_WIDTH(AW), .COUNT_WIDTH(CW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int vectors = 0;
    int miscompares = 0;
    int prods[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // gap < 0 means random bubbles; poke pulses start(len=7) with the first
    // product; start_at_hs presents a start together with the result handshake.
    task automatic burst(input int gap, input int hold, input bit poke, input bit start_at_hs);
        int len;
        int total;
        int exp_sum;
        int g;
        int p;
        bit exp_ovf;
        len   = prods.size();
        total = 0;
        bus.start_i = 1'b1;
        bus.len_i   = CW'(len);
        step();
        bus.start_i = 1'b0;
        bus.len_i   = '0;
        chk("busy_after_start", bus.busy_o, 1);
        chk("ready_in_acc", bus.prod_ready_o, 1);
        for (int i = 0; i < len; i++) begin
            g = (gap < 0) ? $urandom_range(0, 2) : gap;
            if (i == 0 && gap >= 0) g = 0;
            repeat (g) begin
                bus.prod_valid_i = 1'b0;
                bus.prod_i       = DW'($urandom);
                step();
                chk("bubble_ready", bus.prod_ready_o, 1);
                chk("bubble_no_valid", bus.sum_valid_o, 0);
            end
            p = prods[i];
            total += p;
            bus.prod_valid_i = 1'b1;
            bus.prod_i       = DW'(p);
            if (poke && i == 0) begin
                bus.start_i = 1'b1;
                bus.len_i   = CW'(7);
            end
            step();
            bus.start_i      = 1'b0;
            bus.len_i        = '0;
            bus.prod_valid_i = 1'b0;
            if (i < len - 1) chk("valid_early", bus.sum_valid_o, 0);
        end
        exp_sum = (total > MAXV) ? MAXV : total;
        exp_ovf = (total > MAXV);
        chk("valid_latency1", bus.sum_valid_o, 1);
        chk("sum", bus.sum_o, exp_sum);
        chk("ovf", bus.ovf_o, exp_ovf);
        chk("ready_low_done", bus.prod_ready_o, 0);
        repeat (hold) begin
            step();
            chk("hold_valid", bus.sum_valid_o, 1);
            chk("hold_sum", bus.sum_o, exp_sum);
            chk("hold_ovf", bus.ovf_o, exp_ovf);
        end
        bus.sum_ready_i = 1'b1;
        if (start_at_hs) begin
            bus.start_i = 1'b1;
            bus.len_i   = CW'(2);
        end
        step();
        bus.sum_ready_i = 1'b0;
        bus.start_i     = 1'b0;
        bus.len_i       = '0;
        chk("idle_after_hs", bus.busy_o, 0);
        chk("valid_drop_hs", bus.sum_valid_o, 0);
        chk("sum_retained", bus.sum_o, exp_sum);
        chk("ovf_retained", bus.ovf_o, exp_ovf);
        step();
        chk("still_idle", bus.busy_o, 0);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_busy"}, bus.busy_o, 0);
        chk({tag, "_ready"}, bus.prod_ready_o, 0);
        chk({tag, "_valid"}, bus.sum_valid_o, 0);
        chk({tag, "_sum"}, bus.sum_o, 0);
        chk({tag, "_ovf"}, bus.ovf_o, 0);
    endtask

    initial begin
        bus.start_i      = 1'b0;
        bus.len_i        = '0;
        bus.prod_i       = '0;
        bus.prod_valid_i = 1'b0;
        bus.sum_ready_i  = 1'b0;
        #1;
        chk_all_zero("reset");
        step();
        step();
        #2 rst_n = 1'b1;
        step();
        chk("idle_after_reset", bus.busy_o, 0);

        // Basic burst 9, 6, 4
        prods = '{9, 6, 4};
        burst(0, 0, 1'b0, 1'b0);

        // Bubbles and backpressure
        prods = '{15, 15};
        burst(3, 4, 1'b0, 1'b0);

        // Saturation then a clean burst clears overflow
        prods.delete();
        for (int i = 0; i < 20; i++) prods.push_back(15);
        burst(0, 1, 1'b0, 1'b0);
        prods = '{3};
        burst(0, 0, 1'b0, 1'b0);

        // Zero-length start is ignored
        bus.start_i = 1'b1;
        bus.len_i   = '0;
        step();
        bus.start_i = 1'b0;
        chk("zero_len_busy", bus.busy_o, 0);
        chk("zero_len_ready", bus.prod_ready_o, 0);
        step();
        chk("zero_len_valid", bus.sum_valid_o, 0);

        // Start while busy is ignored; start at handshake is dropped
        prods = '{7, 8};
        burst(1, 0, 1'b1, 1'b1);

        // Reset mid-burst
        bus.start_i = 1'b1;
        bus.len_i   = CW'(4);
        step();
        bus.start_i = 1'b0;
        bus.prod_valid_i = 1'b1;
        bus.prod_i = DW'(11);
        step();
        step();
        bus.prod_valid_i = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk_all_zero("async_rst");
        step();
        #2 rst_n = 1'b1;
        repeat (3) begin
            bus.prod_valid_i = 1'b1;
            bus.prod_i = DW'($urandom);
            step();
            chk("post_rst_busy", bus.busy_o, 0);
            chk("post_rst_valid", bus.sum_valid_o, 0);
        end
        bus.prod_valid_i = 1'b0;
        prods = '{5};
        burst(0, 0, 1'b0, 1'b0);

        // Randomized bursts
        for (int b = 0; b < 8; b++) begin
            int n;
            n = $urandom_range(1, 31);
            prods.delete();
            for (int i = 0; i < n; i++) prods.push_back($urandom_range(0, 15));
            burst(-1, $urandom_range(0, 3), 1'b0, 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
